// File: rtl/arith_encoder_core.sv
// arith_encoder_core: two-stage AV1 range coder that updates range/low/cnt by one CDF-coded symbol per clock.
// Stage 1 registers the symbol; stage 2 applies the interval update and byte-emission normalization.
module arith_encoder_core #(
    parameter int GENERAL_RANGE_WIDTH    = 16,
    parameter int GENERAL_LOW_WIDTH      = 24,
    parameter int GENERAL_SYMBOL_WIDTH   = 4,
    parameter int GENERAL_LUT_ADDR_WIDTH = 8,
    parameter int GENERAL_LUT_DATA_WIDTH = 16,
    parameter int GENERAL_D_SIZE         = 4
) (
    input  logic                            general_clk,
    input  logic                            reset,
    input  logic [GENERAL_RANGE_WIDTH-1:0]  general_fl,
    input  logic [GENERAL_RANGE_WIDTH-1:0]  general_fh,
    input  logic [GENERAL_SYMBOL_WIDTH-1:0] general_symbol,
    input  logic [GENERAL_SYMBOL_WIDTH:0]   general_nsyms,
    input  logic                            general_bool,
    output logic [GENERAL_RANGE_WIDTH-1:0]  RANGE_OUTPUT,
    output logic [GENERAL_LOW_WIDTH-1:0]    LOW_OUTPUT
);
    localparam int LW = 40;
    localparam int AW = GENERAL_LUT_ADDR_WIDTH;
    localparam int DW = GENERAL_LUT_DATA_WIDTH;
    localparam int DS = GENERAL_D_SIZE;

    logic [GENERAL_RANGE_WIDTH-1:0]  fl_q, fl_d, fh_q, fh_d, rng_q, rng_d;
    logic [GENERAL_SYMBOL_WIDTH-1:0] sym_q, sym_d;
    logic [GENERAL_SYMBOL_WIDTH:0]   nsyms_q, nsyms_d;
    logic                            bool_q, bool_d, vld_q;
    logic [LW-1:0]                   low_q, low_d, l1, l2;
    logic signed [5:0]               cnt_q, cnt_d, sc, sc2;
    logic [31:0]                     rr, qfl, qfh, nm, u, v, vb, add;
    logic [GENERAL_RANGE_WIDTH-1:0]  r1;
    logic [DS-1:0]                   d;
    logic [DW-1:0]                   m0, m;
    logic                            hi;

    function automatic logic [DS-1:0] lz_lut(input logic [AW-1:0] a);
        lz_lut = DS'(AW);
        for (int i = 0; i < AW; i++)
            if (a[i]) lz_lut = DS'(AW - 1 - i);
    endfunction

    function automatic logic [DW-1:0] mask_lut(input logic [DS-1:0] c);
        mask_lut = (DW'(1) << c) - DW'(1);
    endfunction

    always_comb begin
        fl_d    = general_fl;
        fh_d    = general_fh;
        sym_d   = general_symbol;
        nsyms_d = general_nsyms;
        bool_d  = general_bool;
        rr      = 32'(rng_q);
        qfl     = ((rr >> 8) * (32'(fl_q) >> 6)) >> 1;
        qfh     = ((rr >> 8) * (32'(fh_q) >> 6)) >> 1;
        nm      = 32'(nsyms_q) - 32'd1 - 32'(sym_q);
        u       = qfl + ((nm + 32'd1) << 2);
        v       = qfh + (nm << 2);
        vb      = qfh + 32'd4;
        r1      = GENERAL_RANGE_WIDTH'(bool_q ? (sym_q[0] ? vb : rr - vb) : (fl_q[15] ? rr - v : u - v));
        add     = bool_q ? (sym_q[0] ? rr - vb : 32'd0) : (fl_q[15] ? 32'd0 : rr - u);
        l1      = low_q + LW'(add);
        d       = (r1[15:8] != '0) ? lz_lut(r1[15:8]) : DS'(8) + lz_lut(r1[7:0]);
        sc      = cnt_q + $signed({2'b00, d});
        hi      = sc >= 6'sd8;
        // cnt stays in [-9,-1], so cnt+16 is just its low four bits
        m0      = mask_lut(cnt_q[DS-1:0]);
        m       = hi ? m0 >> 8 : m0;
        sc2     = sc - (hi ? 6'sd16 : 6'sd8);
        l2      = sc[5] ? l1 : l1 & LW'(m);
        rng_d   = vld_q ? r1 << d : rng_q;
        low_d   = vld_q ? l2 << d : low_q;
        cnt_d   = vld_q ? (sc[5] ? sc : sc2) : cnt_q;
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            rng_q <= 16'h8000;
            low_q <= '0;
            cnt_q <= -6'sd9;
        end else begin
            vld_q <= 1'b1;
            rng_q <= rng_d;
            low_q <= low_d;
            cnt_q <= cnt_d;
        end
        fl_q    <= fl_d;
        fh_q    <= fh_d;
        sym_q   <= sym_d;
        nsyms_q <= nsyms_d;
        bool_q  <= bool_d;
    end

    assign RANGE_OUTPUT = rng_q;
    assign LOW_OUTPUT   = low_q[GENERAL_LOW_WIDTH-1:0];
endmodule

// File: tb/tb_arith_encoder_core.sv
// tb_arith_encoder_core: random symbol stream scored against a plain-arithmetic range coder model.
module tb_arith_encoder_core;
    logic        general_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] general_fl = '0, general_fh = '0;
    logic [3:0]  general_symbol = '0;
    logic [4:0]  general_nsyms = 5'd2;
    logic        general_bool = 1'b0;
    logic [15:0] RANGE_OUTPUT;
    logic [23:0] LOW_OUTPUT;

    arith_encoder_core dut (
        .general_clk(general_clk), .reset(reset), .general_fl(general_fl), .general_fh(general_fh),
        .general_symbol(general_symbol), .general_nsyms(general_nsyms), .general_bool(general_bool),
        .RANGE_OUTPUT(RANGE_OUTPUT), .LOW_OUTPUT(LOW_OUTPUT)
    );

    always #5 general_clk = ~general_clk;

    typedef struct {
        int          due;
        logic [15:0] r;
        logic [23:0] l;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    longint m_rng = 32768, m_low = 0;
    int     m_cnt = -9;

    always @(posedge general_clk) cyc <= cyc + 1;

    always @(negedge general_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (RANGE_OUTPUT !== mon_e.r || LOW_OUTPUT !== mon_e.l) begin
                bad++;
                $display("FAIL state cyc=%0d range=%0d low=%0d expected range=%0d low=%0d",
                         cyc, RANGE_OUTPUT, LOW_OUTPUT, mon_e.r, mon_e.l);
            end
        end
    end

    function automatic longint q15(longint r, longint x);
        return ((r >> 8) * (x >> 6)) >> 1;
    endfunction

    task automatic model_step(input bit b, input int s, input int n, input int fl, input int fh);
        longint r = m_rng, l = m_low, m;
        int nn = n - 1, d = 0, c = m_cnt, sc;
        if (b) begin
            if (s % 2 == 1) begin
                l += r - (q15(r, fh) + 4);
                r = q15(r, fh) + 4;
            end else
                r -= q15(r, fh) + 4;
        end else if (fl < 32768) begin
            longint uu = q15(r, fl) + 4 * (nn - s + 1);
            longint vv = q15(r, fh) + 4 * (nn - s);
            l += r - uu;
            r = uu - vv;
        end else
            r -= q15(r, fh) + 4 * (nn - s);
        while (d < 16 && (r << d) < 32768) d++;
        sc = c + d;
        if (sc >= 0) begin
            c += 16;
            m = (longint'(1) << c) - 1;
            if (sc >= 8) begin
                l &= m;
                c -= 8;
                m >>= 8;
            end
            sc = c + d - 24;
            l &= m;
        end
        m_low = l << d;
        m_rng = r << d;
        m_cnt = sc;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge general_clk);
            #1;
        end
    endtask

    task automatic do_reset(input int k);
        reset = 1'b1;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        m_rng = 32768;
        m_low = 0;
        m_cnt = -9;
        repeat (k) begin
            sb.push_back('{cyc + 1, 16'd32768, 24'd0});
            tick(1);
        end
    endtask

    task automatic send(input bit b, input int s, input int n, input int fl, input int fh);
        reset = 1'b0;
        general_bool = b;
        general_symbol = 4'(s);
        general_nsyms = 5'(n);
        general_fl = 16'(fl);
        general_fh = 16'(fh);
        model_step(b, s, n, fl, fh);
        sb.push_back('{cyc + 2, m_rng[15:0], m_low[23:0]});
        tick(1);
    endtask

    initial begin
        int n, s, fl, fh;
        do_reset(2);
        send(0, 0, 2, 32768, 16384);
        tick(1);
        do_reset(2);
        send(0, 1, 2, 16384, 0);
        tick(1);
        do_reset(2);
        send(1, 1, 2, 0, 16384);
        tick(1);
        do_reset(2);
        send(1, 0, 2, 0, 16384);
        tick(1);
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset(1);
            if ($urandom_range(0, 2) == 0) begin
                fh = ($urandom_range(0, 1) == 1) ? int'($urandom_range(30000, 32767)) : int'($urandom_range(1, 32767));
                send(1, int'($urandom_range(0, 1)), 2, 0, fh);
            end else begin
                n = $urandom_range(2, 16);
                s = $urandom_range(0, n - 1);
                fl = (s == 0) ? 32768 : int'($urandom_range(1, 32767));
                fh = (s == n - 1) ? 0 : int'($urandom_range(0, (s == 0) ? 32767 : fl));
                send(0, s, n, fl, fh);
            end
        end
        tick(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
